pifo_ingress_sched: RTL and testbench

- Command scheduler placed directly upstream of the SRAM-based PIFO tree top.
- Buffers push requests from the traffic source in a small FIFO and accepts pop requests from the egress side.
- Serialises both into the tree's single i_push/i_pop issue port, honouring the tree's minimum issue spacing and its capacity.
- Captures the tree's pop result into a registered valid/ready output.

---
 rtl/pifo_sched_pkg.sv | 13 +
 rtl/pifo_sched_fifo.sv | 58 +++++
 rtl/pifo_ingress_sched.sv | 149 ++++++++++++++
 tb/tb_pifo_ingress_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_sched_pkg.sv
// Shared types for the PIFO ingress scheduler: default entry geometry and arbiter winner encoding.
package pifo_sched_pkg;
    localparam int PTW_DEF = 16;
    localparam int MTW_DEF = 32;
    localparam int ENTRY_W = MTW_DEF + PTW_DEF;

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic {
        WIN_PUSH = 1'b0,
        WIN_POP  = 1'b1
    } winner_e;
endpackage

// File: rtl/pifo_sched_fifo.sv
// Synchronous FIFO with registered full/empty flags; head word is presented combinationally on rd_data.
module pifo_sched_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [AW:0]   level_next;
    logic          do_wr;
    logic          do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (do_wr && !do_rd) begin
            level_next = level + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            level_next = level - (AW+1)'(1);
        end
    end

    // Flags are registered from the next level so readiness never depends on this cycle's read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            level <= level_next;
            full  <= (level_next == (AW+1)'(DEPTH));
            empty <= (level_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/pifo_ingress_sched.sv
// Serialises buffered pushes and egress pops onto the PIFO tree's single issue port.
// Optional PIFO_SCHED_STATS_EN adds 32-bit issued-push/issued-pop counters.
module pifo_ingress_sched
    import pifo_sched_pkg::*;
#(
    parameter int PTW       = PTW_DEF,
    parameter int MTW       = MTW_DEF,
    parameter int FDEPTH    = 8,
    parameter int ISSUE_GAP = 2,
    parameter int POP_LAT   = 1,
    parameter int CAPACITY  = 1024,
    parameter int CNTW      = 11
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic                 i_push_valid,
    output logic                 o_push_ready,
    input  logic [MTW+PTW-1:0]   i_push_data,
    input  logic                 i_pop_valid,
    output logic                 o_pop_ready,
    output logic                 o_pop_valid,
    output logic [MTW+PTW-1:0]   o_pop_data,
    input  logic                 i_pop_taken,
    output logic                 o_push,
    output logic [MTW+PTW-1:0]   o_push_data,
    output logic                 o_pop,
    input  logic [MTW+PTW-1:0]   i_pop_data,
    output logic [CNTW-1:0]      o_count,
    output logic                 o_empty,
    output logic                 o_full,
    output logic [31:0]          o_stat_push,
    output logic [31:0]          o_stat_pop
);
    localparam int EW = MTW + PTW;
    localparam int GW = $clog2(ISSUE_GAP + 1);

    logic [EW-1:0]   head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [GW-1:0]   gap;
    logic [CNTW-1:0] count;
    winner_e         last_winner;
    logic            push_elig;
    logic            pop_elig;
    logic            issue_push;
    logic            issue_pop;
    logic            in_flight;
    logic            exit_bit;

    pifo_sched_fifo #(.W(EW), .DEPTH(FDEPTH)) u_fifo (
        .clk     (i_clk),
        .rst     (i_arst),
        .wr_en   (i_push_valid),
        .wr_data (i_push_data),
        .rd_en   (issue_push),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign o_push_ready = !fifo_full;
    assign o_count      = count;
    assign o_empty      = (count == '0);
    assign o_full       = (count == CNTW'(CAPACITY));

    assign push_elig = !fifo_empty && !o_full;
    assign pop_elig  = i_pop_valid && !o_empty && !in_flight && !o_pop_valid;

    always_comb begin
        issue_push = 1'b0;
        issue_pop  = 1'b0;
        if (gap == '0) begin
            if (push_elig && pop_elig) begin
                issue_push = (last_winner == WIN_POP);
                issue_pop  = (last_winner == WIN_PUSH);
            end else begin
                issue_push = push_elig;
                issue_pop  = pop_elig;
            end
        end
    end

    // Stage p1..: in-flight marker for a pop until the tree's data is valid.
    if (POP_LAT == 0) begin : g_lat0
        assign exit_bit  = o_pop;
        assign in_flight = o_pop;
    end else begin : g_latn
        logic [POP_LAT-1:0] vld_p1;
        always_ff @(posedge i_clk or posedge i_arst) begin
            if (i_arst) vld_p1 <= '0;
            else        vld_p1 <= (vld_p1 << 1) | POP_LAT'(o_pop);
        end
        assign exit_bit  = vld_p1[POP_LAT-1];
        assign in_flight = o_pop || (|vld_p1);
    end

    // Stage p0: registered issue strobes, spacing, occupancy and result capture.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_push      <= 1'b0;
            o_pop       <= 1'b0;
            o_pop_ready <= 1'b0;
            o_pop_valid <= 1'b0;
            o_push_data <= '0;
            o_pop_data  <= '0;
            gap         <= '0;
            count       <= '0;
            last_winner <= WIN_POP;
        end else begin
            o_push      <= issue_push;
            o_pop       <= issue_pop;
            o_pop_ready <= issue_pop;
            if (issue_push) o_push_data <= head;
            if (issue_push || issue_pop) begin
                gap         <= GW'(ISSUE_GAP - 1);
                last_winner <= issue_push ? WIN_PUSH : WIN_POP;
            end else if (gap != '0) begin
                gap <= gap - GW'(1);
            end
            if (issue_push)     count <= count + CNTW'(1);
            else if (issue_pop) count <= count - CNTW'(1);
            if (exit_bit) begin
                o_pop_valid <= 1'b1;
                o_pop_data  <= i_pop_data;
            end else if (o_pop_valid && i_pop_taken) begin
                o_pop_valid <= 1'b0;
            end
        end
    end

`ifdef PIFO_SCHED_STATS_EN
    logic [31:0] stat_push;
    logic [31:0] stat_pop;
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            stat_push <= '0;
            stat_pop  <= '0;
        end else begin
            if (issue_push) stat_push <= stat_push + 32'd1;
            if (issue_pop)  stat_pop  <= stat_pop + 32'd1;
        end
    end
    assign o_stat_push = stat_push;
    assign o_stat_pop  = stat_pop;
`else
    assign o_stat_push = '0;
    assign o_stat_pop  = '0;
`endif
endmodule

// File: tb/tb_pifo_ingress_sched.sv
// Directed bench for pifo_ingress_sched with a behavioural min-rank tree (POP_LAT=1) and CAPACITY=4.
module tb_pifo_ingress_sched;
    localparam int PTW = 16;
    localparam int MTW = 32;
    localparam int EW  = MTW + PTW;
    localparam int CAP = 4;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          i_arst;
    logic          i_push_valid;
    logic          o_push_ready;
    logic [EW-1:0] i_push_data;
    logic          i_pop_valid;
    logic          o_pop_ready;
    logic          o_pop_valid;
    logic [EW-1:0] o_pop_data;
    logic          i_pop_taken;
    logic          o_push;
    logic [EW-1:0] o_push_data;
    logic          o_pop;
    logic [EW-1:0] i_pop_data;
    logic [CW-1:0] o_count;
    logic          o_empty;
    logic          o_full;
    logic [31:0]   o_stat_push;
    logic [31:0]   o_stat_pop;

    pifo_ingress_sched #(
        .PTW(PTW), .MTW(MTW), .FDEPTH(8), .ISSUE_GAP(2), .POP_LAT(1),
        .CAPACITY(CAP), .CNTW(CW)
    ) dut (
        .i_clk(clk), .i_arst(i_arst),
        .i_push_valid(i_push_valid), .o_push_ready(o_push_ready), .i_push_data(i_push_data),
        .i_pop_valid(i_pop_valid), .o_pop_ready(o_pop_ready),
        .o_pop_valid(o_pop_valid), .o_pop_data(o_pop_data), .i_pop_taken(i_pop_taken),
        .o_push(o_push), .o_push_data(o_push_data), .o_pop(o_pop), .i_pop_data(i_pop_data),
        .o_count(o_count), .o_empty(o_empty), .o_full(o_full),
        .o_stat_push(o_stat_push), .o_stat_pop(o_stat_pop)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input int unsigned r);
        return {r, r[15:0] ^ 16'hA5A5};
    endfunction

    // Behavioural tree: lowest rank leaves first, data valid one cycle after o_pop.
    logic [EW-1:0] tree_q[$];
    int mi;
    always @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            tree_q.delete();
            i_pop_data <= '0;
        end else begin
            if (o_pop && tree_q.size() > 0) begin
                mi = 0;
                for (int k = 1; k < tree_q.size(); k++)
                    if (tree_q[k][EW-1:PTW] < tree_q[mi][EW-1:PTW]) mi = k;
                i_pop_data <= tree_q[mi];
                tree_q.delete(mi);
            end
            if (o_push) tree_q.push_back(o_push_data);
        end
    end

    int cyc = 0;
    int npush = 0;
    int npop = 0;
    int both_hits = 0;
    int log_op[$];
    int log_cyc[$];
    always @(posedge clk) begin
        cyc++;
        if (o_push) begin npush++; log_op.push_back(1); log_cyc.push_back(cyc); end
        if (o_pop)  begin npop++;  log_op.push_back(2); log_cyc.push_back(cyc); end
        if (o_push && o_pop) both_hits++;
    end

    int n_chk = 0;
    int n_pass = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_arst = 1'b1;
        i_push_valid = 1'b0; i_pop_valid = 1'b0; i_pop_taken = 1'b0; i_push_data = '0;
        @(negedge clk);
        i_arst = 1'b0;
        npush = 0; npop = 0;
        log_op.delete(); log_cyc.delete();
    endtask

    typedef struct {
        bit pv; int unsigned pr; bit qv; bit tk;
        bit ex_push; int unsigned ex_prank; bit ex_pop; bit ex_val; int unsigned ex_vrank; int ex_cnt;
    } vec_t;
    vec_t tbl[20];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 2, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 9, 0, 1, 1, 5, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[4]  = '{0, 0, 0, 1, 1, 2, 0, 0, 0, 2};
        tbl[5]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 2};
        tbl[6]  = '{0, 0, 0, 1, 1, 9, 0, 0, 0, 3};
        tbl[7]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 3};
        tbl[8]  = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 2};
        tbl[9]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 2};
        tbl[10] = '{0, 0, 1, 1, 0, 0, 0, 1, 2, 2};
        tbl[11] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 2};
        tbl[12] = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 1};
        tbl[13] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 1};
        tbl[14] = '{0, 0, 1, 1, 0, 0, 0, 1, 5, 1};
        tbl[15] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 1};
        tbl[16] = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
        tbl[17] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[18] = '{0, 0, 1, 1, 0, 0, 0, 1, 9, 0};
        tbl[19] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};

        i_arst = 1'b1;
        i_push_valid = 1'b0; i_pop_valid = 1'b0; i_pop_taken = 1'b0; i_push_data = '0;
        #1;
        chk("rst.push_ready", o_push_ready, 1);
        chk("rst.empty", o_empty, 1);
        chk("rst.full", o_full, 0);
        chk("rst.count", o_count, 0);
        chk("rst.push", o_push, 0);
        chk("rst.pop", o_pop, 0);
        chk("rst.pop_ready", o_pop_ready, 0);
        chk("rst.pop_valid", o_pop_valid, 0);
        chk("rst.push_data", o_push_data, 0);
        chk("rst.pop_data", o_pop_data, 0);
        chk("rst.stat_push", o_stat_push, 0);
        chk("rst.stat_pop", o_stat_pop, 0);
        repeat (2) @(negedge clk);
        i_arst = 1'b0;

        // Basic push of ranks 5,2,9 followed by held pops.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            i_push_valid = tbl[i].pv;
            i_push_data  = mk(tbl[i].pr);
            i_pop_valid  = tbl[i].qv;
            i_pop_taken  = tbl[i].tk;
            chk($sformatf("t%0d.push", i), o_push, tbl[i].ex_push);
            if (tbl[i].ex_push) chk($sformatf("t%0d.push_data", i), o_push_data, mk(tbl[i].ex_prank));
            chk($sformatf("t%0d.pop", i), o_pop, tbl[i].ex_pop);
            chk($sformatf("t%0d.pop_ready", i), o_pop_ready, tbl[i].ex_pop);
            chk($sformatf("t%0d.pop_valid", i), o_pop_valid, tbl[i].ex_val);
            if (tbl[i].ex_val) chk($sformatf("t%0d.pop_data", i), o_pop_data, mk(tbl[i].ex_vrank));
            chk($sformatf("t%0d.count", i), o_count, tbl[i].ex_cnt);
            chk($sformatf("t%0d.empty", i), o_empty, tbl[i].ex_cnt == 0);
        end

        // Pop requested while empty is never accepted.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("empty%0d.pop_ready", i), o_pop_ready, 0);
        end

        // Capacity: 6 pushes into a 4-entry tree, then fill the FIFO.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); i_push_valid = 1'b1; i_push_data = mk(10 + i);
        end
        @(negedge clk); i_push_valid = 1'b0;
        repeat (16) @(negedge clk);
        chk("cap.count", o_count, 4);
        chk("cap.full", o_full, 1);
        chk("cap.push_ready", o_push_ready, 1);
        chk("cap.npush", npush, 4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); i_push_valid = 1'b1; i_push_data = mk(16 + i);
        end
        @(negedge clk); i_push_valid = 1'b0;
        chk("cap.fifo_full_ready", o_push_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("cap.hold_full%0d", i), o_full, 1);
        end
        i_pop_valid = 1'b1; i_pop_taken = 1'b1;
        for (int k = 0; k < 8 && !o_pop_ready; k++) @(negedge clk);
        chk("cap.pop_accept", o_pop_ready, 1);
        chk("cap.full_after_pop", o_full, 0);
        i_pop_valid = 1'b0;
        for (int k = 0; k < 8 && !o_pop_valid; k++) @(negedge clk);
        chk("cap.pop_valid", o_pop_valid, 1);
        chk("cap.pop_data", o_pop_data, mk(10));
        repeat (8) @(negedge clk);
        chk("cap.npush_after", npush, 5);
        chk("cap.count_after", o_count, 4);
        chk("cap.ready_after", o_push_ready, 1);

        // Backpressure: result held while not taken, no further pops.
        do_reset();
        @(negedge clk); i_push_valid = 1'b1; i_push_data = mk(7);
        @(negedge clk); i_push_data = mk(3);
        @(negedge clk); i_push_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("bp.count", o_count, 2);
        i_pop_valid = 1'b1; i_pop_taken = 1'b0;
        for (int k = 0; k < 10 && !o_pop_valid; k++) @(negedge clk);
        chk("bp.valid", o_pop_valid, 1);
        chk("bp.data", o_pop_data, mk(3));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp.hold_valid%0d", i), o_pop_valid, 1);
            chk($sformatf("bp.hold_data%0d", i), o_pop_data, mk(3));
        end
        chk("bp.npop", npop, 1);
        i_pop_taken = 1'b1;
        for (int k = 0; k < 8 && !o_pop; k++) @(negedge clk);
        chk("bp.next_pop", o_pop, 1);
        for (int k = 0; k < 8 && !o_pop_valid; k++) @(negedge clk);
        chk("bp.next_valid", o_pop_valid, 1);
        chk("bp.next_data", o_pop_data, mk(7));
        i_pop_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp.empty", o_empty, 1);

        // Contention: alternating push/pop spaced by the issue gap.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); i_push_valid = 1'b1; i_push_data = mk(i == 0 ? 30 : (i == 1 ? 20 : 40));
        end
        @(negedge clk); i_push_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("ct.count3", o_count, 3);
        i_pop_valid = 1'b1; i_pop_taken = 1'b1;
        for (int k = 0; k < 8 && !o_pop_ready; k++) @(negedge clk);
        chk("ct.setup_accept", o_pop_ready, 1);
        i_pop_valid = 1'b0;
        for (int k = 0; k < 8 && !o_pop_valid; k++) @(negedge clk);
        chk("ct.setup_data", o_pop_data, mk(20));
        repeat (3) @(negedge clk);
        chk("ct.count2", o_count, 2);
        log_op.delete(); log_cyc.delete();
        i_push_valid = 1'b1; i_push_data = mk(50);
        @(negedge clk); i_push_data = mk(51); i_pop_valid = 1'b1;
        @(negedge clk); i_push_data = mk(52);
        @(negedge clk); i_push_data = mk(53);
        @(negedge clk); i_push_valid = 1'b0;
        repeat (10) @(negedge clk);
        i_pop_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("ct.nops", log_op.size() >= 6, 1);
        if (log_op.size() >= 6) begin
            for (int j = 0; j < 6; j++) begin
                chk($sformatf("ct.op%0d", j), log_op[j], (j % 2 == 0) ? 1 : 2);
                if (j > 0) chk($sformatf("ct.gap%0d", j), log_cyc[j] - log_cyc[j-1], 2);
            end
        end
        chk("never_both", both_hits, 0);

        // Reset while a pop is in flight and the FIFO holds 3 entries.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); i_push_valid = 1'b1; i_push_data = mk(60 + i);
        end
        @(negedge clk); i_push_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("rs.count", o_count, 4);
        chk("rs.full", o_full, 1);
        i_pop_valid = 1'b1; i_pop_taken = 1'b1;
        for (int k = 0; k < 8 && !o_pop; k++) @(negedge clk);
        chk("rs.pop", o_pop, 1);
        i_pop_valid = 1'b0;
`ifdef PIFO_SCHED_STATS_EN
        chk("rs.stat_push_pre", o_stat_push, 4);
        chk("rs.stat_pop_pre", o_stat_pop, 1);
`endif
        i_arst = 1'b1;
        #1;
        chk("rs.count0", o_count, 0);
        chk("rs.empty", o_empty, 1);
        chk("rs.full0", o_full, 0);
        chk("rs.push_ready", o_push_ready, 1);
        chk("rs.pop0", o_pop, 0);
        chk("rs.pop_ready0", o_pop_ready, 0);
        chk("rs.pop_valid0", o_pop_valid, 0);
        chk("rs.stat_push", o_stat_push, 0);
        chk("rs.stat_pop", o_stat_pop, 0);
        @(negedge clk);
        i_arst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("rs.no_valid%0d", i), o_pop_valid, 0);
            chk($sformatf("rs.no_push%0d", i), o_push, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
